iterative_alu: RTL and testbench
================================

Name: iterative_alu

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Adds the following to the existing add/sub/logic/compare set:
  - shifts;
  - an iterative radix-2 multiplier;
  - an iterative radix-2 divider, using RISC-V M-extension result semantics.
- Sits in the execute stage, between operand forwarding and writeback.
- Valid/ready on both sides lets the pipeline stall during multi-cycle ops.

Parameters:
- WIDTH, 32: operand/result width; must be a power of two and at least 8.
- ENABLE_MULDIV, 1: 0 removes the mul/div datapath; those opcodes then complete single-cycle with result 0.

Ports:
- clk  input  1  rising-edge clock
- rstN  input  1  asynchronous active-low reset
- inValid  input  1  operands/op presented
- inReady  output  1  block can accept a request
- operandA  input  WIDTH  first operand (sign per op)
- operandB  input  WIDTH  second operand / shift amount
- opSelect  input  4  operation code
- outValid  output  1  result available
- outReady  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zeroFlag  output  1  registered, equals ~|result

Behaviour:
- Reset (async, rstN=0): state IDLE, inReady=1, outValid=0, result=0, zeroFlag=1, all iteration registers cleared. Reset mid-operation aborts the op; no result is ever emitted.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed): result 1/0, zero-extended.
  - 6 SLTU.
  - 7 SLL, 8 SRL, 9 SRA: shift amount is operandB[log2(WIDTH)-1:0]; upper bits ignored.
  - 10 MUL: low WIDTH bits of the product.
  - 11 MULHU: high WIDTH bits of the unsigned product.
  - 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- Accept: a request is taken when inValid && inReady. inReady = (state==IDLE). Operands and op are captured at acceptance, so input changes afterwards have no effect.
- States:
  - IDLE: on accept of opcodes 0-9 (or any opcode with ENABLE_MULDIV=0), compute and register result, go to DONE. Latency is 1 cycle (outValid high the cycle after accept).
  - MUL: shift-add, one multiplier bit per cycle. Runs a counter from WIDTH-1 down to 0, then goes to DONE. Latency is WIDTH+1 cycles from accept to outValid.
  - DIV: restoring division, one quotient bit per cycle. Signed ops divide magnitudes, then fix signs on the final cycle: quotient negated if the operand signs differ; remainder takes the dividend's sign. Latency is WIDTH+1 cycles.
  - DONE: outValid=1, result/zeroFlag held stable. On outReady go to IDLE. outValid stays high until accepted.
- No request overlap: the next accept is possible the cycle after the DONE handshake (inReady rises then). Back-to-back single-cycle ops therefore sustain one result per 2 cycles.
- Division special cases, resolved at accept with no iteration (latency 1):
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (DIV/REM, dividend = most-negative, divisor = -1): quotient = dividend, remainder = 0.
- Arithmetic wraps modulo 2^WIDTH; no overflow flag.
- zeroFlag is updated in the same cycle as result.

Test Plan:
- Reset mid-DIV:
  - Stimulus: accept DIVU 100/7, assert rstN=0 at cycle 5.
  - Required: outValid=0, result=0, zeroFlag=1, inReady=1 immediately; after reset release no result emerges.
- ALU ops, WIDTH=32:
  - SUB 5-7 -> 0xFFFFFFFE, zeroFlag 0, outValid on the cycle after accept.
  - SLT -1<1 -> 1.
  - SLTU 0xFFFFFFFF<1 -> 0.
  - SRA 0x80000000 by operandB=0x21 (amount 1) -> 0xC0000000.
- MUL:
  - MUL 0xFFFFFFFF*0xFFFFFFFF -> 1.
  - MULHU same operands -> 0xFFFFFFFE.
  - outValid exactly 33 cycles after accept; inReady=0 throughout.
- Division:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIVU 10/0 -> 0xFFFFFFFF; REM 10/0 -> 10.
  - DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0, zeroFlag 1. Both special cases with 1-cycle latency.
- Output backpressure:
  - Stimulus: hold outReady=0 for 10 cycles after an ADD 3+4.
  - Required: result=7 stable and outValid=1 throughout; inReady=0; inputs changed meanwhile are ignored.
  - Raising outReady returns the block to IDLE; the next request is accepted the following cycle.
- Parameter variant WIDTH=8, ENABLE_MULDIV=0:
  - MUL -> 0 in 1 cycle.
  - SLL 0x01 by operandB=0x0F (amount 7) -> 0x80.

Source files
------------

// File: rtl/iterative_alu_if.sv
// rtl/iterative_alu_if.sv - request/response bus for iterative_alu
//
// Purpose: groups the request (inValid/inReady/operands/op) and response
// (outValid/outReady/result/zeroFlag) handshakes of the execute-stage ALU.
// Ports (signals):
//   inValid, inReady       request handshake
//   operandA, operandB     WIDTH-bit operands (operandB also shift amount)
//   opSelect               4-bit operation code
//   outValid, outReady     response handshake
//   result, zeroFlag       registered result and its zero indication
// Modports: master drives requests and consumes results; slave is the ALU.

interface iterative_alu_if #(
   parameter int WIDTH = 32
);
   logic             inValid;
   logic             inReady;
   logic [WIDTH-1:0] operandA;
   logic [WIDTH-1:0] operandB;
   logic [3:0]       opSelect;
   logic             outValid;
   logic             outReady;
   logic [WIDTH-1:0] result;
   logic             zeroFlag;

   modport master (
      output inValid, operandA, operandB, opSelect, outReady,
      input  inReady, outValid, result, zeroFlag
   );

   modport slave (
      input  inValid, operandA, operandB, opSelect, outReady,
      output inReady, outValid, result, zeroFlag
   );
endinterface

// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - handshaked ALU with iterative multiply/divide
//
// Purpose: execute-stage ALU. Add/sub/logic/compare/shift complete one cycle
// after acceptance; MUL/MULHU use a shift-add multiplier and DIV/DIVU/REM/REMU
// a restoring divider, one bit per cycle (WIDTH+1 cycles accept to outValid).
// Ports:
//   clk    rising-edge clock
//   rstN   asynchronous active-low reset
//   bus    iterative_alu_if slave: inValid/inReady, operandA/operandB,
//          opSelect, outValid/outReady, result, zeroFlag
// Parameters: WIDTH (power of two, >= 8); ENABLE_MULDIV (0 = mul/div ops
// complete in one cycle with result 0).

module iterative_alu #(
   parameter int WIDTH         = 32,
   parameter int ENABLE_MULDIV = 1
) (
   input logic            clk,
   input logic            rstN,
   iterative_alu_if.slave bus
);
   localparam int               SW       = $clog2(WIDTH);
   localparam bit               MD       = (ENABLE_MULDIV != 0);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q;
   // Shared iteration registers:
   //   MUL: acc_hi = partial product high half, acc_lo = multiplier/low half,
   //        opnd = multiplicand.
   //   DIV: acc_hi = partial remainder, acc_lo = dividend/quotient bits,
   //        opnd = divisor magnitude.
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic             flip_quo_q, flip_quo_d;
   logic             flip_rem_q, flip_rem_d;

   logic [WIDTH-1:0] a, b;
   logic [SW-1:0]    shamt;
   logic             sign_op, is_rem;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_rem_n, div_quo_n, fix_quo, fix_rem;

   assign a       = bus.operandA;
   assign b       = bus.operandB;
   assign shamt   = bus.operandB[SW-1:0];
   assign sign_op = ~bus.opSelect[0];   // DIV (12) and REM (14) are signed
   assign is_rem  = bus.opSelect[1];    // REM (14) and REMU (15)

   // One shift-add step: conditionally add multiplicand, shift product right.
   assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_hi_n = mul_sum[WIDTH:1];
   assign mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

   // One restoring step. The trial difference is below the divisor, so it
   // fits in WIDTH bits and the low bits of the subtraction are exact.
   assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, opnd_q};
   assign div_rem_n = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
   assign div_quo_n = {acc_lo_q[WIDTH-2:0], div_ge};
   assign fix_quo   = flip_quo_q ? -div_quo_n : div_quo_n;
   assign fix_rem   = flip_rem_q ? -div_rem_n : div_rem_n;

   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      opnd_d     = opnd_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      flip_quo_d = flip_quo_q;
      flip_rem_d = flip_rem_q;
      case (state_q)
         IDLE: begin
            if (bus.inValid) begin
               op_d    = bus.opSelect;
               state_d = DONE;
               case (bus.opSelect)
                  4'd0:  result_d = a + b;
                  4'd1:  result_d = a - b;
                  4'd2:  result_d = a & b;
                  4'd3:  result_d = a | b;
                  4'd4:  result_d = a ^ b;
                  4'd5:  result_d = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
                  4'd6:  result_d = {{(WIDTH-1){1'b0}}, a < b};
                  4'd7:  result_d = a << shamt;
                  4'd8:  result_d = a >> shamt;
                  4'd9:  result_d = $unsigned($signed(a) >>> shamt);
                  4'd10, 4'd11: begin
                     if (MD) begin
                        acc_hi_d = '0;
                        acc_lo_d = a;
                        opnd_d   = b;
                        cnt_d    = SW'(WIDTH-1);
                        state_d  = MUL;
                     end else begin
                        result_d = '0;
                     end
                  end
                  default: begin
                     // Special cases finish here without iterating.
                     if (!MD) begin
                        result_d = '0;
                     end else if (b == '0) begin
                        result_d = is_rem ? a : '1;
                     end else if (sign_op && a == MOST_NEG && b == '1) begin
                        result_d = is_rem ? '0 : a;
                     end else begin
                        acc_hi_d   = '0;
                        acc_lo_d   = (sign_op && a[WIDTH-1]) ? -a : a;
                        opnd_d     = (sign_op && b[WIDTH-1]) ? -b : b;
                        flip_quo_d = sign_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        flip_rem_d = sign_op && a[WIDTH-1];
                        cnt_d      = SW'(WIDTH-1);
                        state_d    = DIV;
                     end
                  end
               endcase
            end
         end
         MUL: begin
            acc_hi_d = mul_hi_n;
            acc_lo_d = mul_lo_n;
            cnt_d    = cnt_q - SW'(1);
            if (cnt_q == '0) begin
               result_d = op_q[0] ? mul_hi_n : mul_lo_n;
               state_d  = DONE;
            end
         end
         DIV: begin
            acc_hi_d = div_rem_n;
            acc_lo_d = div_quo_n;
            cnt_d    = cnt_q - SW'(1);
            if (cnt_q == '0) begin
               result_d = op_q[1] ? fix_rem : fix_quo;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (bus.outReady) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q    <= IDLE;
         result_q   <= '0;
         zero_q     <= 1'b1;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         opnd_q     <= '0;
         cnt_q      <= '0;
         op_q       <= '0;
         flip_quo_q <= 1'b0;
         flip_rem_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         result_q   <= result_d;
         zero_q     <= ~|result_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         opnd_q     <= opnd_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         flip_quo_q <= flip_quo_d;
         flip_rem_q <= flip_rem_d;
      end
   end

   assign bus.inReady  = (state_q == IDLE);
   assign bus.outValid = (state_q == DONE);
   assign bus.result   = result_q;
   assign bus.zeroFlag = zero_q;
endmodule

// File: tb/tb_iterative_alu.sv
// tb/tb_iterative_alu.sv - directed self-checking bench for iterative_alu

module tb_iterative_alu;
   logic clk = 1'b0;
   logic rstN;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   iterative_alu_if #(.WIDTH(32)) bus32 ();
   iterative_alu_if #(.WIDTH(8))  bus8 ();

   iterative_alu #(.WIDTH(32), .ENABLE_MULDIV(1)) u_alu32 (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus32)
   );

   iterative_alu #(.WIDTH(8), .ENABLE_MULDIV(0)) u_alu8 (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus8)
   );

   // Issue one request on the 32-bit unit, measure accept-to-outValid latency,
   // capture the result, then complete the output handshake.
   task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic zf, output int lat, output bit rdy_seen);
      int w;
      w = 0;
      while (!bus32.inReady && w < 100) begin
         @(posedge clk); #1; w++;
      end
      checks++;
      if (bus32.inReady !== 1'b1) begin errors++; $display("FAIL run32_inready actual=%b required=1", bus32.inReady); end
      bus32.opSelect = op; bus32.operandA = a; bus32.operandB = b; bus32.inValid = 1'b1;
      @(posedge clk); #1;
      bus32.inValid = 1'b0;
      lat = 1; rdy_seen = 1'b0;
      while (!bus32.outValid && lat < 100) begin
         if (bus32.inReady) rdy_seen = 1'b1;
         @(posedge clk); #1; lat++;
      end
      res = bus32.result; zf = bus32.zeroFlag;
      bus32.outReady = 1'b1;
      @(posedge clk); #1;
      bus32.outReady = 1'b0;
   endtask

   task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] res, output logic zf, output int lat);
      bus8.opSelect = op; bus8.operandA = a; bus8.operandB = b; bus8.inValid = 1'b1;
      @(posedge clk); #1;
      bus8.inValid = 1'b0;
      lat = 1;
      while (!bus8.outValid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      res = bus8.result; zf = bus8.zeroFlag;
      bus8.outReady = 1'b1;
      @(posedge clk); #1;
      bus8.outReady = 1'b0;
   endtask

   task automatic test_reset;
      rstN = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus32.inReady !== 1'b1) begin errors++; $display("FAIL rst_inready actual=%b required=1", bus32.inReady); end
      checks++; if (bus32.outValid !== 1'b0) begin errors++; $display("FAIL rst_outvalid actual=%b required=0", bus32.outValid); end
      checks++; if (bus32.result !== 32'h0) begin errors++; $display("FAIL rst_result actual=%h required=0", bus32.result); end
      checks++; if (bus32.zeroFlag !== 1'b1) begin errors++; $display("FAIL rst_zero actual=%b required=1", bus32.zeroFlag); end
      checks++; if (bus8.outValid !== 1'b0) begin errors++; $display("FAIL rst8_outvalid actual=%b required=0", bus8.outValid); end
      rstN = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_alu_ops;
      logic [31:0] r; logic z; int l; bit rs;
      run32(4'd1, 32'd5, 32'd7, r, z, l, rs);
      checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_result actual=%h required=fffffffe", r); end
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL sub_zero actual=%b required=0", z); end
      checks++; if (l !== 1) begin errors++; $display("FAIL sub_latency actual=%0d required=1", l); end
      run32(4'd5, 32'hFFFFFFFF, 32'd1, r, z, l, rs);
      checks++; if (r !== 32'd1) begin errors++; $display("FAIL slt_result actual=%h required=1", r); end
      run32(4'd6, 32'hFFFFFFFF, 32'd1, r, z, l, rs);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL sltu_result actual=%h required=0", r); end
      checks++; if (z !== 1'b1) begin errors++; $display("FAIL sltu_zero actual=%b required=1", z); end
      run32(4'd9, 32'h80000000, 32'h21, r, z, l, rs);
      checks++; if (r !== 32'hC0000000) begin errors++; $display("FAIL sra_result actual=%h required=c0000000", r); end
      run32(4'd8, 32'h80000000, 32'h24, r, z, l, rs);
      checks++; if (r !== 32'h08000000) begin errors++; $display("FAIL srl_result actual=%h required=08000000", r); end
      run32(4'd4, 32'hF0F0F0F0, 32'hFF00FF00, r, z, l, rs);
      checks++; if (r !== 32'h0FF00FF0) begin errors++; $display("FAIL xor_result actual=%h required=0ff00ff0", r); end
   endtask

   task automatic test_mul;
      logic [31:0] r; logic z; int l; bit rs;
      run32(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, r, z, l, rs);
      checks++; if (r !== 32'd1) begin errors++; $display("FAIL mul_result actual=%h required=1", r); end
      checks++; if (l !== 33) begin errors++; $display("FAIL mul_latency actual=%0d required=33", l); end
      checks++; if (rs !== 1'b0) begin errors++; $display("FAIL mul_inready actual=%b required=0", rs); end
      run32(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, r, z, l, rs);
      checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu_result actual=%h required=fffffffe", r); end
      checks++; if (l !== 33) begin errors++; $display("FAIL mulhu_latency actual=%0d required=33", l); end
      run32(4'd10, 32'd12345, 32'd678, r, z, l, rs);
      checks++; if (r !== 32'd8369910) begin errors++; $display("FAIL mul_small actual=%0d required=8369910", r); end
   endtask

   task automatic test_div;
      logic [31:0] r; logic z; int l; bit rs;
      run32(4'd12, 32'hFFFFFFF9, 32'd2, r, z, l, rs);
      checks++; if (r !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_result actual=%h required=fffffffd", r); end
      checks++; if (l !== 33) begin errors++; $display("FAIL div_latency actual=%0d required=33", l); end
      checks++; if (rs !== 1'b0) begin errors++; $display("FAIL div_inready actual=%b required=0", rs); end
      run32(4'd14, 32'hFFFFFFF9, 32'd2, r, z, l, rs);
      checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_result actual=%h required=ffffffff", r); end
      run32(4'd13, 32'd100, 32'd7, r, z, l, rs);
      checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_result actual=%0d required=14", r); end
      run32(4'd15, 32'd100, 32'd7, r, z, l, rs);
      checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_result actual=%0d required=2", r); end
      run32(4'd13, 32'd10, 32'd0, r, z, l, rs);
      checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_result actual=%h required=ffffffff", r); end
      checks++; if (l !== 1) begin errors++; $display("FAIL divu0_latency actual=%0d required=1", l); end
      run32(4'd14, 32'd10, 32'd0, r, z, l, rs);
      checks++; if (r !== 32'd10) begin errors++; $display("FAIL rem0_result actual=%h required=0000000a", r); end
      checks++; if (l !== 1) begin errors++; $display("FAIL rem0_latency actual=%0d required=1", l); end
      run32(4'd12, 32'h80000000, 32'hFFFFFFFF, r, z, l, rs);
      checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL divovf_result actual=%h required=80000000", r); end
      checks++; if (l !== 1) begin errors++; $display("FAIL divovf_latency actual=%0d required=1", l); end
      run32(4'd14, 32'h80000000, 32'hFFFFFFFF, r, z, l, rs);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL removf_result actual=%h required=0", r); end
      checks++; if (z !== 1'b1) begin errors++; $display("FAIL removf_zero actual=%b required=1", z); end
      checks++; if (l !== 1) begin errors++; $display("FAIL removf_latency actual=%0d required=1", l); end
   endtask

   task automatic test_backpressure;
      bus32.opSelect = 4'd0; bus32.operandA = 32'd3; bus32.operandB = 32'd4; bus32.inValid = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         bus32.opSelect = 4'd1; bus32.operandA = 32'd100 + i; bus32.operandB = 32'd1;
         checks++; if (bus32.outValid !== 1'b1) begin errors++; $display("FAIL bp_outvalid cycle=%0d actual=%b required=1", i, bus32.outValid); end
         checks++; if (bus32.result !== 32'd7) begin errors++; $display("FAIL bp_result cycle=%0d actual=%0d required=7", i, bus32.result); end
         checks++; if (bus32.inReady !== 1'b0) begin errors++; $display("FAIL bp_inready cycle=%0d actual=%b required=0", i, bus32.inReady); end
         @(posedge clk); #1;
      end
      bus32.opSelect = 4'd0; bus32.operandA = 32'd1; bus32.operandB = 32'd1;
      bus32.outReady = 1'b1;
      @(posedge clk); #1;
      bus32.outReady = 1'b0;
      checks++; if (bus32.inReady !== 1'b1) begin errors++; $display("FAIL bp_release_inready actual=%b required=1", bus32.inReady); end
      checks++; if (bus32.outValid !== 1'b0) begin errors++; $display("FAIL bp_release_outvalid actual=%b required=0", bus32.outValid); end
      @(posedge clk); #1;
      bus32.inValid = 1'b0;
      checks++; if (bus32.outValid !== 1'b1) begin errors++; $display("FAIL bp_next_outvalid actual=%b required=1", bus32.outValid); end
      checks++; if (bus32.result !== 32'd2) begin errors++; $display("FAIL bp_next_result actual=%0d required=2", bus32.result); end
      bus32.outReady = 1'b1;
      @(posedge clk); #1;
      bus32.outReady = 1'b0;
   endtask

   task automatic test_narrow;
      logic [7:0] r; logic z; int l;
      run8(4'd10, 8'd5, 8'd3, r, z, l);
      checks++; if (r !== 8'h00) begin errors++; $display("FAIL w8_mul_result actual=%h required=00", r); end
      checks++; if (l !== 1) begin errors++; $display("FAIL w8_mul_latency actual=%0d required=1", l); end
      checks++; if (z !== 1'b1) begin errors++; $display("FAIL w8_mul_zero actual=%b required=1", z); end
      run8(4'd7, 8'h01, 8'h0F, r, z, l);
      checks++; if (r !== 8'h80) begin errors++; $display("FAIL w8_sll_result actual=%h required=80", r); end
      run8(4'd13, 8'd10, 8'd0, r, z, l);
      checks++; if (r !== 8'h00) begin errors++; $display("FAIL w8_divu_result actual=%h required=00", r); end
      run8(4'd0, 8'hFF, 8'h02, r, z, l);
      checks++; if (r !== 8'h01) begin errors++; $display("FAIL w8_add_wrap actual=%h required=01", r); end
   endtask

   task automatic test_reset_mid_div;
      bit seen;
      bus32.opSelect = 4'd13; bus32.operandA = 32'd100; bus32.operandB = 32'd7; bus32.inValid = 1'b1;
      @(posedge clk); #1;
      bus32.inValid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      checks++; if (bus32.outValid !== 1'b0) begin errors++; $display("FAIL mid_busy_outvalid actual=%b required=0", bus32.outValid); end
      rstN = 1'b0;
      #1;
      checks++; if (bus32.outValid !== 1'b0) begin errors++; $display("FAIL mid_rst_outvalid actual=%b required=0", bus32.outValid); end
      checks++; if (bus32.result !== 32'd0) begin errors++; $display("FAIL mid_rst_result actual=%h required=0", bus32.result); end
      checks++; if (bus32.zeroFlag !== 1'b1) begin errors++; $display("FAIL mid_rst_zero actual=%b required=1", bus32.zeroFlag); end
      checks++; if (bus32.inReady !== 1'b1) begin errors++; $display("FAIL mid_rst_inready actual=%b required=1", bus32.inReady); end
      @(posedge clk); #1;
      rstN = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus32.outValid) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_no_result actual=%b required=0", seen); end
   endtask

   initial begin
      rstN = 1'b0;
      bus32.inValid = 1'b0; bus32.outReady = 1'b0; bus32.opSelect = 4'd0;
      bus32.operandA = '0;  bus32.operandB = '0;
      bus8.inValid  = 1'b0; bus8.outReady  = 1'b0; bus8.opSelect  = 4'd0;
      bus8.operandA = '0;   bus8.operandB  = '0;
      test_reset();
      test_alu_ops();
      test_mul();
      test_div();
      test_backpressure();
      test_narrow();
      test_reset_mid_div();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
